qpu_ifu_bjp_ctrl: RTL

//  Sequencer behind the IFU mini-decoder that resolves conditional branches (bxx) in the fetch stage.

---
 rtl/qpu_ifu_bjp_ctrl.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/qpu_ifu_bjp_ctrl.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// qpu_ifu_bjp_ctrl
//
// Resolves conditional branches (bxx) in the fetch stage, behind the IFU
// mini-decoder. A branch is captured from the IR stage, waits out pending
// writes to its source registers, borrows the RF read port it shares with the
// EXU, compares the operands and emits one taken/not-taken result with the
// redirect PC. Non-branch instructions are consumed in zero cycles.
//
// Handshakes (all valid/ready style):
//   ir_valid/ir_ready : an instruction moves when both are high on a rising
//                       edge. ir_valid must hold its payload until then.
//                       ir_ready does not depend on ir_valid.
//   rf_req/rf_gnt     : the read is performed on the edge where both are high.
//                       Read data returns the following cycle. rf_req and the
//                       indices stay stable until that edge.
//   bjp_vld           : one-cycle pulse. There is no back-pressure.
//
// Ports
//   clk, rst_n                       clock, asynchronous active-low reset
//   ir_valid/ir_ready/ir_pc/ir_funct3   IR stage instruction
//   dec_*                            mini-decoder fields for the IR instruction
//   wb_pend_vec                      outstanding register writes, one bit per reg
//   rf_req/rf_gnt/rf_rs*idx/rf_rs*data  shared RF read port
//   flush                            abort any branch in progress
//   bjp_vld/bjp_taken/bjp_tgt_pc     resolution result to the PC generator
//   stall_cnt                        saturating count of dependency-stall cycles
//   dbg_state                        current sequencer state
//                                    (0 IDLE, 1 DEP, 2 REQ, 3 DATA)
//
// XLEN must be at least PC_W. Only the low PC_W bits of the immediate
// take part in the target addition.
// ---------------------------------------------------------------------------
module qpu_ifu_bjp_ctrl #(
    parameter int PC_W    = 32,
    parameter int XLEN    = 32,
    parameter int RFIDX_W = 5,
    parameter int STALL_W = 8
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    ir_valid,
    output logic                    ir_ready,
    input  logic [PC_W-1:0]         ir_pc,
    input  logic [2:0]              ir_funct3,
    input  logic                    dec_bxx,
    input  logic                    dec_rs1en,
    input  logic                    dec_rs2en,
    input  logic [RFIDX_W-1:0]      dec_rs1idx,
    input  logic [RFIDX_W-1:0]      dec_rs2idx,
    input  logic [XLEN-1:0]         dec_bjp_imm,
    input  logic [2**RFIDX_W-1:0]   wb_pend_vec,
    output logic                    rf_req,
    input  logic                    rf_gnt,
    output logic [RFIDX_W-1:0]      rf_rs1idx,
    output logic [RFIDX_W-1:0]      rf_rs2idx,
    input  logic [XLEN-1:0]         rf_rs1data,
    input  logic [XLEN-1:0]         rf_rs2data,
    input  logic                    flush,
    output logic                    bjp_vld,
    output logic                    bjp_taken,
    output logic [PC_W-1:0]         bjp_tgt_pc,
    output logic [STALL_W-1:0]      stall_cnt,
    output logic [1:0]              dbg_state
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DEP  = 2'd1;
    localparam logic [1:0] ST_REQ  = 2'd2;
    localparam logic [1:0] ST_DATA = 2'd3;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    logic [1:0]         state_q, state_d;
    logic [STALL_W-1:0] stall_q, stall_d;
    logic               vld_q, vld_d;
    logic               taken_q, taken_d;
    logic [PC_W-1:0]    tgt_q, tgt_d;

    // Captured branch context
    logic [PC_W-1:0]    pc_q;
    logic [PC_W-1:0]    imm_q;
    logic [2:0]         funct3_q;
    logic [RFIDX_W-1:0] rs1idx_q, rs2idx_q;
    logic               rs1en_q, rs2en_q;

    logic               capture;
    logic               hazard;
    logic [XLEN-1:0]    op1, op2;
    logic               cond;
    logic               unused_imm;

    // Only the low PC_W bits of the immediate are needed for the target.
    assign unused_imm = ^dec_bjp_imm;

    // A flush in IDLE refuses the instruction so it is re-presented afterwards.
    assign ir_ready = (state_q == ST_IDLE) && !flush;
    assign capture  = ir_valid && ir_ready && dec_bxx;

    // x0 is hard-wired, so a pending bit on index 0 is never a real dependency.
    assign hazard = (rs1en_q && (rs1idx_q != '0) && wb_pend_vec[rs1idx_q]) ||
                    (rs2en_q && (rs2idx_q != '0) && wb_pend_vec[rs2idx_q]);

    assign op1 = rs1en_q ? rf_rs1data : '0;
    assign op2 = rs2en_q ? rf_rs2data : '0;

    always_comb begin
        cond = 1'b0;
        case (funct3_q)
            F3_BEQ:  cond = (op1 == op2);
            F3_BNE:  cond = (op1 != op2);
            F3_BLT:  cond = ($signed(op1) <  $signed(op2));
            F3_BGE:  cond = ($signed(op1) >= $signed(op2));
            F3_BLTU: cond = (op1 <  op2);
            F3_BGEU: cond = (op1 >= op2);
            default: cond = 1'b0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        stall_d = stall_q;
        vld_d   = 1'b0;
        taken_d = taken_q;
        tgt_d   = tgt_q;
        case (state_q)
            ST_IDLE: begin
                if (capture) state_d = ST_DEP;
            end
            ST_DEP: begin
                if (hazard) begin
                    if (!flush && !(&stall_q)) stall_d = stall_q + STALL_W'(1);
                end else begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (rf_gnt) state_d = ST_DATA;
            end
            default: begin
                state_d = ST_IDLE;
                vld_d   = 1'b1;
                taken_d = cond;
                tgt_d   = cond ? (pc_q + imm_q) : (pc_q + PC_W'(4));
            end
        endcase
        // An aborted branch produces no result and leaves the last one visible.
        if (flush) begin
            state_d = ST_IDLE;
            vld_d   = 1'b0;
            taken_d = taken_q;
            tgt_d   = tgt_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            stall_q <= '0;
            vld_q   <= 1'b0;
            taken_q <= 1'b0;
            tgt_q   <= '0;
        end else begin
            state_q <= state_d;
            stall_q <= stall_d;
            vld_q   <= vld_d;
            taken_q <= taken_d;
            tgt_q   <= tgt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q     <= '0;
            imm_q    <= '0;
            funct3_q <= '0;
            rs1idx_q <= '0;
            rs2idx_q <= '0;
            rs1en_q  <= 1'b0;
            rs2en_q  <= 1'b0;
        end else if (capture) begin
            pc_q     <= ir_pc;
            imm_q    <= dec_bjp_imm[PC_W-1:0];
            funct3_q <= ir_funct3;
            rs1idx_q <= dec_rs1idx;
            rs2idx_q <= dec_rs2idx;
            rs1en_q  <= dec_rs1en;
            rs2en_q  <= dec_rs2en;
        end
    end

    assign rf_req     = (state_q == ST_REQ);
    assign rf_rs1idx  = rs1idx_q;
    assign rf_rs2idx  = rs2idx_q;
    assign bjp_vld    = vld_q;
    assign bjp_taken  = taken_q;
    assign bjp_tgt_pc = tgt_q;
    assign stall_cnt  = stall_q;
    assign dbg_state  = state_q;

endmodule
